// File: rtl/friscv_pkg.sv
// friscv_pkg: shared types and constants for the data-memory responder.
//   ARCH          - data/address width
//   dmem_state_t  - responder FSM states
//   F3_*          - RV32I load/store func3 encodings
//   f3_size()     - access size in bytes for a load/store func3
package friscv_pkg;

    localparam int ARCH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } dmem_state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Size lives in func3[1:0] for both loads and stores; illegal encodings
    // are rejected separately, so their size value is irrelevant.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    f3_size = 3'd1;
            2'd1:    f3_size = 3'd2;
            default: f3_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM, DEPTH x ARCH, per-byte write enables.
//   clk   - clock
//   en    - access enable (read and/or write this cycle)
//   be    - byte write enables
//   addr  - word address
//   wdata - write data
//   rdata - registered read data (updates only on enabled cycles)
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int ARCH  = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int NB    = ARCH / 8
) (
    input  logic            clk,
    input  logic            en,
    input  logic [NB-1:0]   be,
    input  logic [AW-1:0]   addr,
    input  logic [ARCH-1:0] wdata,
    output logic [ARCH-1:0] rdata
);

    logic [ARCH-1:0] mem [DEPTH];

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < NB; b++)
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I load/store responder in front of a word-wide RAM.
// Handles byte/half/word accesses at any byte offset; accesses that straddle
// a word boundary take a second RAM cycle.
//   clk_in, rst_in                     - clock, async active-high reset
//   req_valid_in / req_ready_out       - request handshake
//   req_we_in, req_func3_in            - store flag, RV32I func3
//   req_addr_in, req_wdata_in          - byte address, store data
//   rsp_valid_out / rsp_ready_in       - response handshake
//   rsp_rdata_out, rsp_err_out         - load data (0 for stores/errors), error
module dmem_responder
    import friscv_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int ARCH  = friscv_pkg::ARCH
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            req_valid_in,
    output logic            req_ready_out,
    input  logic            req_we_in,
    input  logic [2:0]      req_func3_in,
    input  logic [ARCH-1:0] req_addr_in,
    input  logic [ARCH-1:0] req_wdata_in,
    output logic            rsp_valid_out,
    input  logic            rsp_ready_in,
    output logic [ARCH-1:0] rsp_rdata_out,
    output logic            rsp_err_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = ARCH / 8;

    dmem_state_t state, state_nx;

    logic            we_q, err_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [AW-1:0]   word_q;
    logic [ARCH-1:0] wdata_q, lo_q;

    // ---- request decode at accept ----
    logic [2:0]    size_in, size_q;
    logic [ARCH:0] last_in;
    logic          bad_f3, oob, err_in, accept, split_q;

    assign size_in = f3_size(req_func3_in);
    // One extra bit so an access near the top of the address space cannot wrap.
    assign last_in = {1'b0, req_addr_in} + (ARCH+1)'(size_in) - (ARCH+1)'(1);
    assign bad_f3  = req_we_in ? (req_func3_in > 3'd2)
                               : (req_func3_in == 3'd3 || req_func3_in >= 3'd6);
    assign oob     = last_in >= (ARCH+1)'(DEPTH * 4);
    assign err_in  = bad_f3 | oob;

    assign req_ready_out = (state == IDLE) && !rst_in;
    assign accept        = req_valid_in && req_ready_out;

    assign size_q  = f3_size(f3_q);
    assign split_q = (3'({1'b0, off_q}) + size_q) > 3'd4;

    // ---- FSM ----
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept)       state_nx = err_in ? RESP : ACC0;
            ACC0:                   state_nx = split_q ? ACC1 : RESP;
            ACC1:                   state_nx = RESP;
            RESP: if (rsp_ready_in) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we_in;
            err_q   <= err_in;
            f3_q    <= req_func3_in;
            off_q   <= req_addr_in[1:0];
            word_q  <= req_addr_in[AW+1:2];
            wdata_q <= req_wdata_in;
        end
    end

    // ---- RAM port ----
    logic [ARCH-1:0]   ram_rdata, ram_wdata;
    logic [NB-1:0]     ram_be, be_mask;
    logic [2*ARCH-1:0] wide_d;
    logic [2*NB-1:0]   wide_be;
    logic              ram_en;

    assign be_mask = NB'((1 << size_q) - 1);
    // Store data and enables laid out across two adjacent words; the low
    // word is written in ACC0, the high word in ACC1.
    assign wide_d  = {{ARCH{1'b0}}, wdata_q} << {off_q, 3'b000};
    assign wide_be = {{NB{1'b0}}, be_mask} << off_q;

    assign ram_en    = (state == ACC0) || (state == ACC1);
    assign ram_wdata = (state == ACC1) ? wide_d[2*ARCH-1:ARCH] : wide_d[ARCH-1:0];
    assign ram_be    = !we_q ? '0 :
                       (state == ACC1) ? wide_be[2*NB-1:NB] : wide_be[NB-1:0];

    dmem_ram #(.DEPTH(DEPTH), .ARCH(ARCH)) u_ram (
        .clk   (clk_in),
        .en    (ram_en),
        .be    (ram_be),
        .addr  ((state == ACC1) ? word_q + AW'(1) : word_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Low word of a split load is parked here while the high word is read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)              lo_q <= '0;
        else if (state == ACC1)  lo_q <= ram_rdata;
    end

    // ---- load formatting (RAM output is held in RESP, so this is stable) ----
    logic [2*ARCH-1:0] window;
    logic [ARCH-1:0]   low, ld_data;

    assign window = split_q ? {ram_rdata, lo_q} : {{ARCH{1'b0}}, ram_rdata};
    assign low    = ARCH'(window >> {off_q, 3'b000});

    always_comb begin
        ld_data = low;
        case (f3_q)
            F3_LB:  ld_data = {{(ARCH-8){low[7]}},   low[7:0]};
            F3_LH:  ld_data = {{(ARCH-16){low[15]}}, low[15:0]};
            F3_LBU: ld_data = {{(ARCH-8){1'b0}},     low[7:0]};
            F3_LHU: ld_data = {{(ARCH-16){1'b0}},    low[15:0]};
            default: ld_data = low;
        endcase
    end

    assign rsp_valid_out = (state == RESP);
    assign rsp_err_out   = (state == RESP) && err_q;
    assign rsp_rdata_out = ((state == RESP) && !err_q && !we_q) ? ld_data : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [2:0]  req_f3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int failures = 0;

    dmem_responder #(.DEPTH(1024), .ARCH(32)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .req_valid_in  (req_valid),
        .req_ready_out (req_ready),
        .req_we_in     (req_we),
        .req_func3_in  (req_f3),
        .req_addr_in   (req_addr),
        .req_wdata_in  (req_wdata),
        .rsp_valid_out (rsp_valid),
        .rsp_ready_in  (rsp_ready),
        .rsp_rdata_out (rsp_rdata),
        .rsp_err_out   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request; lat = cycle index (1 = first cycle after the
    // handshake edge) in which rsp_valid is first seen, 99 on timeout.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) lat = 99;
        rd = rsp_rdata;
        er = rsp_err;
        if (rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(we, f3, a, wd, rd, er, lat);
        chk({tag, ".rdata"}, rd, exp_rd);
        chk({tag, ".err"}, 32'(er), 32'(exp_er));
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 0);
        chk("rst.valid", 32'(rsp_valid), 0);
        chk("rst.rdata", rsp_rdata, 0);
        chk("rst.err",   32'(rsp_err), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst.ready_after", 32'(req_ready), 1);

        // aligned word and sub-word accesses
        xact("sw10",   1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
        xact("lw10",   0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
        xact("lb13",   0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 2);
        xact("lbu13",  0, 3'd4, 32'h13, 32'h0, 32'h000000DE, 0, 2);
        xact("lh12",   0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 2);
        xact("lhu12",  0, 3'd5, 32'h12, 32'h0, 32'h0000DEAD, 0, 2);
        xact("lb11",   0, 3'd0, 32'h11, 32'h0, 32'hFFFFFFBE, 0, 2);

        // split store between known neighbour bytes
        xact("sb20",   1, 3'd0, 32'h20, 32'h0000005A, 32'h0, 0, 2);
        xact("sb25",   1, 3'd0, 32'h25, 32'h000000A5, 32'h0, 0, 2);
        xact("sw21",   1, 3'd2, 32'h21, 32'h11223344, 32'h0, 0, 3);
        xact("lbu20",  0, 3'd4, 32'h20, 32'h0, 32'h5A, 0, 2);
        xact("lbu21",  0, 3'd4, 32'h21, 32'h0, 32'h44, 0, 2);
        xact("lbu22",  0, 3'd4, 32'h22, 32'h0, 32'h33, 0, 2);
        xact("lbu23",  0, 3'd4, 32'h23, 32'h0, 32'h22, 0, 2);
        xact("lbu24",  0, 3'd4, 32'h24, 32'h0, 32'h11, 0, 2);
        xact("lbu25",  0, 3'd4, 32'h25, 32'h0, 32'hA5, 0, 2);
        xact("lw21",   0, 3'd2, 32'h21, 32'h0, 32'h11223344, 0, 3);
        xact("lh23",   0, 3'd1, 32'h23, 32'h0, 32'h00001122, 0, 3);
        xact("sh27",   1, 3'd1, 32'h27, 32'h0000BEEF, 32'h0, 0, 3);
        xact("lhu27",  0, 3'd5, 32'h27, 32'h0, 32'h0000BEEF, 0, 3);

        // boundary and illegal encodings
        xact("swlast", 1, 3'd2, 32'hFFC, 32'h12345678, 32'h0, 0, 2);
        xact("lwoob",  0, 3'd2, 32'h1000, 32'h0, 32'h0, 1, 1);
        xact("swoob",  1, 3'd2, 32'hFFE, 32'hCAFEF00D, 32'h0, 1, 1);
        xact("lhoob",  0, 3'd1, 32'hFFF, 32'h0, 32'h0, 1, 1);
        xact("lwlast", 0, 3'd2, 32'hFFC, 32'h0, 32'h12345678, 0, 2);
        xact("lf3_3",  0, 3'd3, 32'h10, 32'h0, 32'h0, 1, 1);
        xact("lf3_6",  0, 3'd6, 32'h10, 32'h0, 32'h0, 1, 1);
        xact("sf3_4",  1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h0, 1, 1);
        xact("lw10b",  0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);

        // response back-pressure
        rsp_ready = 1'b0;
        do_req(0, 3'd2, 32'h10, 32'h0, rd, er, lat);
        chk("stall.lat", 32'(lat), 2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall.valid", 32'(rsp_valid), 1);
            chk("stall.rdata", rsp_rdata, 32'hDEADBEEF);
            chk("stall.ready", 32'(req_ready), 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall.release_valid", 32'(rsp_valid), 0);
        chk("stall.release_ready", 32'(req_ready), 1);

        // reset during the second half of a split store
        xact("clr30", 1, 3'd2, 32'h30, 32'h0, 32'h0, 0, 2);
        xact("clr34", 1, 3'd2, 32'h34, 32'h0, 32'h0, 0, 2);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd2;
        req_addr = 32'h31; req_wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort.acc_ready", 32'(req_ready), 0);
        rst = 1'b1;
        #1;
        chk("abort.valid", 32'(rsp_valid), 0);
        chk("abort.ready", 32'(req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort.ready_after", 32'(req_ready), 1);
        xact("abort.lw30", 0, 3'd2, 32'h30, 32'h0, 32'hBBCCDD00, 0, 2);
        xact("abort.lw34", 0, 3'd2, 32'h34, 32'h0, 32'h00000000, 0, 2);
        xact("keep.lw10",  0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
